// File: rtl/jtag_usr_responder.sv
// rtl/jtag_usr_responder.sv - JTAG TAP responder with USER1 function register and USER2 fabric port
//
// Purpose:
//   Oversamples the JTAG pins with clk160, runs an IEEE 1149.1 TAP controller
//   with a 10-bit IR, and serves two user instructions:
//     USER1 (10'h3C2): 8-bit register whose Update-DR writes func.
//     USER2 (10'h3C3): pulses for the fabric, plus a 16-bit status shadow
//                      register that is scanned out when func is 2 or 3.
//   Any other instruction selects the 1-bit BYPASS register.
//
// Ports:
//   clk160     - system clock, every register on its rising edge
//   sys_rst    - synchronous active-high reset
//   tck/tms/tdi- asynchronous JTAG pins
//   tdo        - JTAG data out (changes after TCK falling edges in Shift states)
//   status     - 16-bit word captured into the shadow register (func 3)
//   func       - current function code, func_strb pulses when it is written
//   usr2_cap   - pulse on entry to Capture-DR with USER2 active
//   usr2_sh    - pulse per Shift-DR TCK rise with USER2 active, usr2_tdi valid
//   usr2_upd   - pulse on entry to Update-DR with USER2 active
//   usr2_tdo   - fabric return bit scanned out for USER2 when func is not 2/3
//   tap_rst    - high while the TAP is in Test-Logic-Reset

module jtag_usr_responder (
  input  logic        clk160,
  input  logic        sys_rst,
  input  logic        tck,
  input  logic        tms,
  input  logic        tdi,
  output logic        tdo,
  input  logic [15:0] status,
  output logic [7:0]  func,
  output logic        func_strb,
  output logic        usr2_cap,
  output logic        usr2_sh,
  output logic        usr2_upd,
  output logic        usr2_tdi,
  input  logic        usr2_tdo,
  output logic        tap_rst
);

  typedef enum logic [3:0] {
    TLR, RTI,
    SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } tap_state_t;

  localparam logic [9:0] IR_USER1  = 10'h3C2;
  localparam logic [9:0] IR_USER2  = 10'h3C3;
  localparam logic [9:0] IR_BYPASS = 10'h3FF;
  localparam logic [9:0] IR_CAP    = 10'b0000000001;

  // Pin pipelines: [0] and [1] form the synchronizer, [2] is the edge register.
  // tms/tdi go through the same depth so they stay aligned with the TCK edge.
  logic [2:0] tck_pipe;
  logic [2:0] tms_pipe;
  logic [2:0] tdi_pipe;
  logic       r_ev;
  logic       f_ev;
  logic       tms_s;
  logic       tdi_s;

  always_ff @(posedge clk160) begin
    if (sys_rst) begin
      tck_pipe <= 3'b000;
      tms_pipe <= 3'b000;
      tdi_pipe <= 3'b000;
      r_ev     <= 1'b0;
      f_ev     <= 1'b0;
    end else begin
      tck_pipe <= {tck_pipe[1:0], tck};
      tms_pipe <= {tms_pipe[1:0], tms};
      tdi_pipe <= {tdi_pipe[1:0], tdi};
      // Registered so the event lands three clk160 cycles after the pin edge.
      r_ev     <= tck_pipe[1] & ~tck_pipe[2];
      f_ev     <= ~tck_pipe[1] & tck_pipe[2];
    end
  end

  assign tms_s = tms_pipe[2];
  assign tdi_s = tdi_pipe[2];

  function automatic tap_state_t tap_next(input tap_state_t s, input logic m);
    case (s)
      TLR:      tap_next = m ? TLR    : RTI;
      RTI:      tap_next = m ? SEL_DR : RTI;
      SEL_DR:   tap_next = m ? SEL_IR : CAP_DR;
      CAP_DR:   tap_next = m ? EX1_DR : SH_DR;
      SH_DR:    tap_next = m ? EX1_DR : SH_DR;
      EX1_DR:   tap_next = m ? UPD_DR : PAUSE_DR;
      PAUSE_DR: tap_next = m ? EX2_DR : PAUSE_DR;
      EX2_DR:   tap_next = m ? UPD_DR : SH_DR;
      UPD_DR:   tap_next = m ? SEL_DR : RTI;
      SEL_IR:   tap_next = m ? TLR    : CAP_IR;
      CAP_IR:   tap_next = m ? EX1_IR : SH_IR;
      SH_IR:    tap_next = m ? EX1_IR : SH_IR;
      EX1_IR:   tap_next = m ? UPD_IR : PAUSE_IR;
      PAUSE_IR: tap_next = m ? EX2_IR : PAUSE_IR;
      EX2_IR:   tap_next = m ? UPD_IR : SH_IR;
      UPD_IR:   tap_next = m ? SEL_DR : RTI;
      default:  tap_next = TLR;
    endcase
  endfunction

  tap_state_t  tap_state;
  tap_state_t  tap_nxt;
  logic [9:0]  ir;
  logic [9:0]  ir_act;
  logic [7:0]  user1_sr;
  logic [15:0] shadow;
  logic        bypass_r;
  logic        is_user1;
  logic        is_user2;
  logic        func_sh;
  logic        tdo_src;

  assign tap_nxt  = tap_next(tap_state, tms_s);
  assign is_user1 = (ir_act == IR_USER1);
  assign is_user2 = (ir_act == IR_USER2);
  assign func_sh  = (func == 8'h02) || (func == 8'h03);

  always_comb begin
    tdo_src = bypass_r;
    if (tap_state == SH_IR) begin
      tdo_src = ir[0];
    end else if (is_user1) begin
      tdo_src = user1_sr[0];
    end else if (is_user2) begin
      tdo_src = func_sh ? shadow[0] : usr2_tdo;
    end
  end

  always_ff @(posedge clk160) begin
    if (sys_rst) begin
      tap_state <= TLR;
      tap_rst   <= 1'b1;
      ir        <= IR_CAP;
      ir_act    <= IR_BYPASS;
      user1_sr  <= 8'h00;
      shadow    <= 16'h0000;
      bypass_r  <= 1'b0;
      func      <= 8'h00;
      func_strb <= 1'b0;
      usr2_cap  <= 1'b0;
      usr2_sh   <= 1'b0;
      usr2_upd  <= 1'b0;
      usr2_tdi  <= 1'b0;
      tdo       <= 1'b0;
    end else begin
      func_strb <= 1'b0;
      usr2_cap  <= 1'b0;
      usr2_sh   <= 1'b0;
      usr2_upd  <= 1'b0;

      // Self-clearing function codes drop back the cycle after their strobe.
      if (func_strb && ((func == 8'h0D) || (func == 8'h0F))) begin
        func <= 8'h00;
      end

      if (r_ev) begin
        tap_state <= tap_nxt;
        tap_rst   <= (tap_nxt == TLR);

        // Capture/shift act on the TCK rise that leaves the state.
        case (tap_state)
          CAP_IR: ir <= IR_CAP;
          SH_IR:  ir <= {tdi_s, ir[9:1]};
          CAP_DR: begin
            bypass_r <= 1'b0;
            if (is_user1) begin
              user1_sr <= func;
            end
            if (is_user2 && (func == 8'h03)) begin
              shadow <= status;
            end
          end
          SH_DR: begin
            bypass_r <= tdi_s;
            if (is_user1) begin
              user1_sr <= {tdi_s, user1_sr[7:1]};
            end
            if (is_user2) begin
              usr2_sh  <= 1'b1;
              usr2_tdi <= tdi_s;
              if (func_sh) begin
                shadow <= {tdi_s, shadow[15:1]};
              end
            end
          end
          default: ;
        endcase

        // Entry-based actions: the last shift bit is already in place here.
        if (tap_nxt == UPD_IR) begin
          ir_act <= ir;
        end
        if (is_user2 && (tap_nxt == CAP_DR)) begin
          usr2_cap <= 1'b1;
        end
        if (tap_nxt == UPD_DR) begin
          if (is_user2) begin
            usr2_upd <= 1'b1;
          end
          if (is_user1) begin
            func      <= user1_sr;
            func_strb <= 1'b1;
          end
        end
      end

      if (f_ev && ((tap_state == SH_IR) || (tap_state == SH_DR))) begin
        tdo <= tdo_src;
      end

      if (tap_state == TLR) begin
        ir_act <= IR_BYPASS;
      end
    end
  end

endmodule

// File: tb/tb_jtag_usr_responder.sv
// tb/tb_jtag_usr_responder.sv - self-checking bench for jtag_usr_responder

module tb_jtag_usr_responder;

  localparam int HALF = 6;

  logic        clk160 = 1'b0;
  logic        sys_rst = 1'b1;
  logic        tck = 1'b0;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        tdo;
  logic [15:0] status = 16'h0000;
  logic [7:0]  func;
  logic        func_strb;
  logic        usr2_cap;
  logic        usr2_sh;
  logic        usr2_upd;
  logic        usr2_tdi;
  logic        usr2_tdo = 1'b0;
  logic        tap_rst;

  int checks = 0;
  int failures = 0;

  int          strb_cnt = 0;
  int          cap_cnt = 0;
  int          sh_cnt = 0;
  int          upd_cnt = 0;
  logic [7:0]  strb_func = 8'h00;
  logic [7:0]  after_func = 8'h00;
  logic        prev_strb = 1'b0;
  logic        sh_obs[$];
  logic        exp_q[$];
  logic        exp_sh[$];

  jtag_usr_responder dut (
    .clk160    (clk160),
    .sys_rst   (sys_rst),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .status    (status),
    .func      (func),
    .func_strb (func_strb),
    .usr2_cap  (usr2_cap),
    .usr2_sh   (usr2_sh),
    .usr2_upd  (usr2_upd),
    .usr2_tdi  (usr2_tdi),
    .usr2_tdo  (usr2_tdo),
    .tap_rst   (tap_rst)
  );

  always #5 clk160 = ~clk160;

  always @(negedge clk160) begin
    prev_strb <= func_strb;
    if (prev_strb) after_func <= func;
    if (func_strb) begin
      strb_cnt  <= strb_cnt + 1;
      strb_func <= func;
    end
    if (usr2_cap) cap_cnt <= cap_cnt + 1;
    if (usr2_upd) upd_cnt <= upd_cnt + 1;
    if (usr2_sh) begin
      sh_cnt <= sh_cnt + 1;
      sh_obs.push_back(usr2_tdi);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk160);
  endtask

  task automatic tck_pulse(input logic m, input logic d, output logic sampled);
    tms = m;
    tdi = d;
    wait_clk(HALF);
    sampled = tdo;
    tck = 1'b1;
    wait_clk(HALF);
    tck = 1'b0;
  endtask

  task automatic tms_step(input logic m);
    logic x;
    tck_pulse(m, 1'b0, x);
  endtask

  task automatic goto_idle();
    repeat (5) tms_step(1'b1);
    tms_step(1'b0);
  endtask

  task automatic scan_ir(input logic [9:0] v, output logic [9:0] got);
    got = '0;
    tms_step(1'b1);
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    for (int i = 0; i < 10; i++) tck_pulse(i == 9, v[i], got[i]);
    tms_step(1'b1);
    tms_step(1'b0);
  endtask

  task automatic scan_dr(input logic [15:0] v, input int n, output logic [15:0] got);
    got = '0;
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    for (int i = 0; i < n; i++) tck_pulse(i == n - 1, v[i], got[i]);
    tms_step(1'b1);
    tms_step(1'b0);
  endtask

  task automatic compare_tdo(input string name, input logic [15:0] got, input int n);
    logic e;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s bit %0d: no expected value queued", name, i);
      end else begin
        e = exp_q.pop_front();
        if (got[i] !== e) begin
          failures++;
          $display("FAIL %s bit %0d: tdo=%b expected %b", name, i, got[i], e);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic set_func(input logic [7:0] v);
    logic [9:0]  gi;
    logic [15:0] gd;
    scan_ir(10'h3C2, gi);
    scan_dr({8'h00, v}, 8, gd);
    wait_clk(4);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    wait_clk(4);
    checks++; if (tap_rst !== 1'b1) begin failures++; $display("FAIL reset_tap_rst: got %b expected 1", tap_rst); end
    checks++; if (func !== 8'h00) begin failures++; $display("FAIL reset_func: got %h expected 00", func); end
    checks++; if (tdo !== 1'b0) begin failures++; $display("FAIL reset_tdo: got %b expected 0", tdo); end
    checks++;
    if ({func_strb, usr2_cap, usr2_sh, usr2_upd} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_pulses: got %b expected 0000", {func_strb, usr2_cap, usr2_sh, usr2_upd});
    end
    sys_rst = 1'b0;
    wait_clk(3);
  endtask

  task automatic test_tlr();
    logic [7:0] pat;
    goto_idle();
    wait_clk(2);
    checks++; if (tap_rst !== 1'b0) begin failures++; $display("FAIL tlr_idle: tap_rst=%b expected 0", tap_rst); end
    pat = 8'b11111100;
    for (int i = 0; i < 8; i++) tms_step(pat[i]);
    wait_clk(2);
    checks++; if (tap_rst !== 1'b1) begin failures++; $display("FAIL tlr_seq: tap_rst=%b expected 1", tap_rst); end
  endtask

  task automatic test_user1();
    logic [9:0]  gi;
    logic [15:0] gd;
    int s0;
    goto_idle();
    s0 = strb_cnt;
    for (int i = 0; i < 10; i++) exp_q.push_back(i == 0);
    scan_ir(10'h3C2, gi);
    compare_tdo("user1_ir_tdo", {6'b0, gi}, 10);
    scan_dr(16'h000C, 8, gd);
    wait_clk(4);
    checks++; if (func !== 8'h0C) begin failures++; $display("FAIL user1_func: got %h expected 0C", func); end
    checks++; if (strb_cnt - s0 != 1) begin failures++; $display("FAIL user1_strb: got %0d expected 1", strb_cnt - s0); end
  endtask

  task automatic test_user2_pulses();
    logic [9:0]  gi;
    logic [15:0] gd;
    int c0, h0, u0, s0, base;
    logic e;
    usr2_tdo = 1'b1;
    scan_ir(10'h3C3, gi);
    c0 = cap_cnt; h0 = sh_cnt; u0 = upd_cnt; s0 = strb_cnt; base = sh_obs.size();
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(1'b1);
      exp_sh.push_back(1'b1);
    end
    scan_dr(16'h0FFF, 12, gd);
    wait_clk(4);
    checks++; if (cap_cnt - c0 != 1) begin failures++; $display("FAIL usr2_cap_count: got %0d expected 1", cap_cnt - c0); end
    checks++; if (sh_cnt - h0 != 12) begin failures++; $display("FAIL usr2_sh_count: got %0d expected 12", sh_cnt - h0); end
    checks++; if (upd_cnt - u0 != 1) begin failures++; $display("FAIL usr2_upd_count: got %0d expected 1", upd_cnt - u0); end
    checks++; if (strb_cnt - s0 != 0) begin failures++; $display("FAIL usr2_no_strb: got %0d expected 0", strb_cnt - s0); end
    for (int i = base; i < sh_obs.size(); i++) begin
      checks++;
      e = (exp_sh.size() != 0) ? exp_sh.pop_front() : 1'bx;
      if (sh_obs[i] !== e) begin failures++; $display("FAIL usr2_tdi %0d: got %b expected %b", i - base, sh_obs[i], e); end
    end
    exp_sh.delete();
    compare_tdo("usr2_fabric_tdo", gd, 12);
    checks++; if (func !== 8'h0C) begin failures++; $display("FAIL usr2_func_kept: got %h expected 0C", func); end
  endtask

  task automatic test_status_capture();
    logic [9:0]  gi;
    logic [15:0] gd;
    logic [15:0] st;
    logic [15:0] shifted;
    set_func(8'h03);
    st = 16'hA5C3;
    status = st;
    shifted = 16'h1234;
    scan_ir(10'h3C3, gi);
    for (int i = 0; i < 16; i++) exp_q.push_back(st[i]);
    scan_dr(shifted, 16, gd);
    compare_tdo("status_f3_tdo", gd, 16);
    set_func(8'h02);
    status = 16'hFFFF;
    scan_ir(10'h3C3, gi);
    for (int i = 0; i < 16; i++) exp_q.push_back(shifted[i]);
    scan_dr(16'h0000, 16, gd);
    compare_tdo("shadow_f2_tdo", gd, 16);
  endtask

  task automatic test_autoreset();
    logic [7:0] codes [2];
    int s0;
    codes[0] = 8'h0D;
    codes[1] = 8'h0F;
    for (int k = 0; k < 2; k++) begin
      s0 = strb_cnt;
      set_func(codes[k]);
      wait_clk(4);
      checks++; if (strb_cnt - s0 != 1) begin failures++; $display("FAIL auto_strb_count: got %0d expected 1", strb_cnt - s0); end
      checks++; if (strb_func !== codes[k]) begin failures++; $display("FAIL auto_strb_func: got %h expected %h", strb_func, codes[k]); end
      checks++; if (after_func !== 8'h00) begin failures++; $display("FAIL auto_next_func: got %h expected 00", after_func); end
      checks++; if (func !== 8'h00) begin failures++; $display("FAIL auto_func_final: got %h expected 00", func); end
    end
  endtask

  task automatic test_bypass();
    logic [9:0]  gi;
    logic [15:0] gd;
    logic [15:0] pat;
    pat = 16'h00B4;
    scan_ir(10'h3FF, gi);
    for (int i = 0; i < 8; i++) exp_q.push_back((i == 0) ? 1'b0 : pat[i - 1]);
    scan_dr(pat, 8, gd);
    compare_tdo("bypass_tdo", gd, 8);
  endtask

  task automatic test_abort();
    logic [9:0] gi;
    logic       x;
    int u0, s0;
    scan_ir(10'h3C3, gi);
    u0 = upd_cnt;
    s0 = strb_cnt;
    tms_step(1'b1);
    tms_step(1'b0);
    tms_step(1'b0);
    for (int i = 0; i < 5; i++) tck_pulse(1'b0, 1'b1, x);
    sys_rst = 1'b1;
    wait_clk(3);
    sys_rst = 1'b0;
    wait_clk(3);
    checks++; if (upd_cnt - u0 != 0) begin failures++; $display("FAIL abort_no_upd: got %0d expected 0", upd_cnt - u0); end
    checks++; if (strb_cnt - s0 != 0) begin failures++; $display("FAIL abort_no_strb: got %0d expected 0", strb_cnt - s0); end
    checks++; if (func !== 8'h00) begin failures++; $display("FAIL abort_func: got %h expected 00", func); end
    checks++; if (tap_rst !== 1'b1) begin failures++; $display("FAIL abort_tap_rst: got %b expected 1", tap_rst); end
  endtask

  task automatic test_back_to_back();
    logic [9:0]  gi;
    logic [15:0] gd;
    int s0;
    tms_step(1'b0);
    s0 = strb_cnt;
    for (int i = 0; i < 10; i++) exp_q.push_back(i == 0);
    scan_ir(10'h3C2, gi);
    compare_tdo("recover_ir_tdo", {6'b0, gi}, 10);
    scan_dr(16'h005A, 8, gd);
    wait_clk(4);
    checks++; if (func !== 8'h5A) begin failures++; $display("FAIL recover_func: got %h expected 5A", func); end
    checks++; if (strb_cnt - s0 != 1) begin failures++; $display("FAIL recover_strb: got %0d expected 1", strb_cnt - s0); end
  endtask

  initial begin
    test_reset();
    test_tlr();
    test_user1();
    test_user2_pulses();
    test_status_capture();
    test_autoreset();
    test_bypass();
    test_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
